// File: rtl/step_sched_if.sv
// Step request/acknowledge handshake between the scheduler
// and the solver step input.
interface step_sched_if;
  logic step_req;
  logic step_ack;

  modport master (
    output step_req,
    input  step_ack
  );

  modport slave (
    input  step_req,
    output step_ack
  );
endinterface

// File: rtl/step_sched.sv
// Programmable clock-enable divider and single-step scheduler
// producing a req/ack step handshake for the knapsack solver.
module step_sched #(
  parameter int unsigned CNT = 5000000,
  parameter int unsigned CW  = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_en,
  input  logic [1:0]   div_sel,
  input  logic         step_btn,
  input  logic         missed_clr,
  step_sched_if.master bus,
  output logic         tick,
  output logic         clk_slow,
  output logic [7:0]   missed_cnt,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    PAUSE = 2'b00,
    RUN   = 2'b01,
    REQ   = 2'b10
  } st_e;

  localparam logic [CW-1:0] CNT_W = CW'(CNT);

  st_e           st;
  st_e           st_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] per_q;
  logic [CW-1:0] per;
  logic          sync1;
  logic          sync2;
  logic          btn_d;
  logic          btn_pulse;
  logic          active;
  logic          req_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_d     <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      sync1     <= step_btn;
      sync2     <= sync1;
      btn_d     <= sync2;
      btn_pulse <= sync2 & ~btn_d;
    end
  end

  // New period is picked up straight from div_sel at cnt==0
  assign per    = (cnt == '0) ? (CNT_W >> div_sel) : per_q;
  assign active = run_en && (st != PAUSE);
  assign tick   = active && (cnt == per - CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      per_q <= '0;
    end else begin
      if (cnt == '0)
        per_q <= per;
      if (!active || tick)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      PAUSE: begin
        if (btn_pulse)
          st_nxt = REQ;
        else if (run_en)
          st_nxt = RUN;
      end
      RUN: begin
        if (!run_en)
          st_nxt = PAUSE;
        else if (tick)
          st_nxt = REQ;
      end
      REQ: begin
        if (bus.step_ack)
          st_nxt = run_en ? RUN : PAUSE;
      end
      default: st_nxt = PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= PAUSE;
      req_q <= 1'b0;
    end else begin
      st    <= st_nxt;
      req_q <= (st_nxt == REQ);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_slow   <= 1'b0;
      missed_cnt <= 8'd0;
    end else begin
      if (tick)
        clk_slow <= ~clk_slow;
      if (missed_clr)
        missed_cnt <= 8'd0;
      else if (tick && st == REQ && missed_cnt != 8'hFF)
        missed_cnt <= missed_cnt + 8'd1;
    end
  end

  assign bus.step_req = req_q;
  assign state        = st;

endmodule
